// File: rtl/lutram_mp.sv
// Multi-read-port distributed RAM: one byte-enabled write port, write-first or
// read-first reads, optional output register, and a sweep engine that wipes the array.
module lutram_mp #(
  parameter int                  ADDR_WIDTH  = 6,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  WORDS       = 64,
  parameter int                  READ_PORTS  = 2,
  parameter bit                  WRITE_FIRST = 1'b1,
  parameter bit                  OUT_REG     = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  output logic                             busy,
  input  logic                             we,
  input  logic [ADDR_WIDTH-1:0]            w_addr,
  input  logic [DATA_WIDTH/8-1:0]          w_be,
  input  logic [DATA_WIDTH-1:0]            w_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] r_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] r_data
);

  localparam int                    NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(WORDS - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   ram [WORDS];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [NB-1:0]           wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;

  // The sweep takes the write port; user writes only land in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = w_addr;
    wr_be   = w_be;
    wr_data = w_data;
    case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_be   = '1;
        wr_data = CLEAR_VALUE;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        wr_en = we && ({1'b0, w_addr} < DEPTH);
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) ram[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_raw;
    logic [DATA_WIDTH-1:0] rd_frc;

    assign ra = r_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    if (WRITE_FIRST) begin : g_wf
      // Registered address, async read: a same-edge write is already in the array.
      logic [ADDR_WIDTH-1:0] ra_q;
      always_ff @(posedge clk) begin
        if (!rst_n) ra_q <= '0;
        else        ra_q <= ra;
      end
      assign rd_raw = ({1'b0, ra_q} < DEPTH) ? ram[ra_q] : '0;
    end else begin : g_rf
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= ({1'b0, ra} < DEPTH) ? ram[ra] : '0;
      end
      assign rd_raw = rd_q;
    end

    assign rd_frc = busy ? CLEAR_VALUE : rd_raw;

    if (OUT_REG) begin : g_or
      logic [DATA_WIDTH-1:0] out_q;
      always_ff @(posedge clk) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= rd_frc;
      end
      assign r_data[p*DATA_WIDTH +: DATA_WIDTH] = out_q;
    end else begin : g_nor
      assign r_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_frc;
    end
  end

endmodule

// File: tb/tb_lutram_mp.sv
// Bench for lutram_mp: four configurations share one stimulus stream; a behavioural
// model feeds per-instance scoreboards, plus a hand-computed vector table.
module tb_lutram_mp;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NP = 2;
  localparam int ND = 4;
  localparam logic [DW-1:0] CV3 = 32'h5A5A_A5A5;

  localparam int          PW  [ND] = '{64, 64, 48, 64};
  localparam bit          PWF [ND] = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam int          POR [ND] = '{0, 1, 0, 1};
  localparam logic [31:0] PCV [ND] = '{32'h0, 32'h0, 32'h0, CV3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clear, we;
  logic [AW-1:0]     w_addr;
  logic [3:0]        w_be;
  logic [DW-1:0]     w_data;
  logic [NP*AW-1:0]  r_addr;
  logic [NP*DW-1:0]  rd [ND];
  logic              bz [ND];

  lutram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(PW[0]), .READ_PORTS(NP),
              .WRITE_FIRST(PWF[0]), .OUT_REG(POR[0] == 1), .CLEAR_VALUE(PCV[0])) u_d0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(bz[0]), .we(we), .w_addr(w_addr),
    .w_be(w_be), .w_data(w_data), .r_addr(r_addr), .r_data(rd[0]));
  lutram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(PW[1]), .READ_PORTS(NP),
              .WRITE_FIRST(PWF[1]), .OUT_REG(POR[1] == 1), .CLEAR_VALUE(PCV[1])) u_d1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(bz[1]), .we(we), .w_addr(w_addr),
    .w_be(w_be), .w_data(w_data), .r_addr(r_addr), .r_data(rd[1]));
  lutram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(PW[2]), .READ_PORTS(NP),
              .WRITE_FIRST(PWF[2]), .OUT_REG(POR[2] == 1), .CLEAR_VALUE(PCV[2])) u_d2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(bz[2]), .we(we), .w_addr(w_addr),
    .w_be(w_be), .w_data(w_data), .r_addr(r_addr), .r_data(rd[2]));
  lutram_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(PW[3]), .READ_PORTS(NP),
              .WRITE_FIRST(PWF[3]), .OUT_REG(POR[3] == 1), .CLEAR_VALUE(PCV[3])) u_d3 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(bz[3]), .we(we), .w_addr(w_addr),
    .w_be(w_be), .w_data(w_data), .r_addr(r_addr), .r_data(rd[3]));

  typedef struct {
    int          due;
    int          port;
    logic [31:0] ev;
    bit          hand;
  } sb_t;

  typedef struct {
    bit          we;
    logic [5:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [5:0]  ra;
    logic [31:0] e0, e1, e2, e3;
  } vec_t;

  logic [31:0] mem [ND][64];
  bit          mbz [ND];
  int          mcnt[ND];
  sb_t         sbq [ND][$];
  int          nb  [ND];
  int          cyc_n, n_chk, n_pass;
  bit          hv;
  logic [31:0] hexp[ND];
  vec_t        tab [10];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc%0d: got %h expected %h", nm, d, cyc_n, act, exp);
  endtask

  // One clock cycle: inputs already driven; model steps at the edge, outputs checked at negedge.
  task automatic cyc();
    logic [31:0] pre[ND][NP];
    logic [31:0] v;
    int a;
    if (!rst_n) for (int d = 0; d < ND; d++) sbq[d].delete();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP; p++) begin
        a = int'(r_addr[p*AW +: AW]);
        pre[d][p] = (a < PW[d]) ? mem[d][a] : '0;
      end
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        mbz[d] = 1'b1; mcnt[d] = 0;
      end else if (mbz[d]) begin
        mem[d][mcnt[d]] = PCV[d];
        if (mcnt[d] == PW[d] - 1) begin mbz[d] = 1'b0; mcnt[d] = 0; end
        else mcnt[d]++;
      end else begin
        if (we && int'(w_addr) < PW[d])
          for (int k = 0; k < 4; k++) if (w_be[k]) mem[d][w_addr][8*k +: 8] = w_data[8*k +: 8];
        if (clear) begin mbz[d] = 1'b1; mcnt[d] = 0; end
      end
    end
    if (rst_n) begin
      for (int d = 0; d < ND; d++)
        for (int p = 0; p < NP; p++) begin
          a = int'(r_addr[p*AW +: AW]);
          v = PWF[d] ? ((a < PW[d]) ? mem[d][a] : '0) : pre[d][p];
          if (mbz[d]) v = PCV[d];
          if (hv && p == 0) v = hexp[d];
          sbq[d].push_back('{cyc_n + 1 + POR[d], p, v, hv && p == 0});
        end
    end
    @(negedge clk);
    cyc_n++;
    for (int d = 0; d < ND; d++) begin
      sb_t e;
      chk("busy", d, {31'b0, bz[d]}, {31'b0, mbz[d]});
      while (sbq[d].size() > 0 && sbq[d][0].due <= cyc_n) begin
        e = sbq[d].pop_front();
        chk(e.hand ? "table_rd" : "sb_rd", d, rd[d][e.port*DW +: DW], e.ev);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      we = 1'b0; clear = 1'b0; hv = 1'b0;
      r_addr = (NP*AW)'($urandom);
      cyc();
    end
  endtask

  task automatic write(input logic [5:0] a, input logic [31:0] d);
    we = 1'b1; w_addr = a; w_be = 4'hF; w_data = d; clear = 1'b0; hv = 1'b0;
    r_addr = (NP*AW)'($urandom);
    cyc();
    we = 1'b0;
  endtask

  task automatic sweep_read();
    for (int i = 0; i < 64; i++) begin
      we = 1'b0; clear = 1'b0; hv = 1'b0;
      r_addr = {6'(63 - i), 6'(i)};
      cyc();
    end
    idle(3);
  endtask

  // Counts busy cycles per instance; optionally fires dropped writes and a second clear mid-sweep.
  task automatic count_busy(input bit poke);
    bit any;
    for (int d = 0; d < ND; d++) nb[d] = 0;
    for (int k = 0; k < 200; k++) begin
      any = 1'b0;
      for (int d = 0; d < ND; d++) if (bz[d]) begin nb[d]++; any = 1'b1; end
      if (!any) break;
      hv = 1'b0;
      r_addr = (NP*AW)'($urandom);
      we = poke && k < 5; w_addr = 6'd10; w_be = 4'hF; w_data = 32'hCAFE_F00D;
      clear = poke && k == 30;
      cyc();
    end
    we = 1'b0; clear = 1'b0;
    for (int d = 0; d < ND; d++) chk("busy_len", d, 32'(nb[d]), 32'(PW[d]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    tab[0] = '{1'b1, 6'd5,  4'hF, 32'hAABBCCDD, 6'd5,  32'hAABBCCDD, 32'h0, 32'h0, 32'hAABBCCDD};
    tab[1] = '{1'b1, 6'd5,  4'h5, 32'h11223344, 6'd5,  32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAA22CC44};
    tab[2] = '{1'b0, 6'd0,  4'h0, 32'h0,        6'd5,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    tab[3] = '{1'b1, 6'd3,  4'hF, 32'h1,        6'd0,  32'h0, 32'h0, 32'h0, CV3};
    tab[4] = '{1'b1, 6'd3,  4'hF, 32'h2,        6'd3,  32'h2, 32'h1, 32'h1, 32'h2};
    tab[5] = '{1'b0, 6'd0,  4'h0, 32'h0,        6'd3,  32'h2, 32'h2, 32'h2, 32'h2};
    tab[6] = '{1'b1, 6'd5,  4'h0, 32'hFFFFFFFF, 6'd5,  32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    tab[7] = '{1'b1, 6'd63, 4'hF, 32'hDEADBEEF, 6'd63, 32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF};
    tab[8] = '{1'b1, 6'd50, 4'hF, 32'h12345678, 6'd50, 32'h12345678, 32'h0, 32'h0, 32'h12345678};
    tab[9] = '{1'b0, 6'd0,  4'h0, 32'h0,        6'd50, 32'h12345678, 32'h12345678, 32'h0, 32'h12345678};

    for (int d = 0; d < ND; d++) begin
      mbz[d] = 1'b1; mcnt[d] = 0;
      for (int a = 0; a < 64; a++) mem[d][a] = PCV[d];
    end
    cyc_n = 0; n_chk = 0; n_pass = 0; hv = 1'b0;
    rst_n = 1'b0; clear = 1'b0; we = 1'b0; w_addr = '0; w_be = '0; w_data = '0; r_addr = '0;

    cyc(); cyc();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP; p++) chk("reset_rd", d, rd[d][p*DW +: DW], 32'h0);

    rst_n = 1'b1;
    count_busy(1'b0);
    sweep_read();

    for (int i = 0; i < 10; i++) begin
      we = tab[i].we; w_addr = tab[i].wa; w_be = tab[i].be; w_data = tab[i].wd;
      clear = 1'b0; r_addr = {tab[i].ra, tab[i].ra};
      hv = 1'b1;
      hexp[0] = tab[i].e0; hexp[1] = tab[i].e1; hexp[2] = tab[i].e2; hexp[3] = tab[i].e3;
      cyc();
    end
    idle(3);

    // Clear with data present; simultaneous write commits first, then gets swept.
    write(6'd7, 32'h7777_7777);
    write(6'd40, 32'h4040_4040);
    we = 1'b1; w_addr = 6'd9; w_be = 4'hF; w_data = 32'h9999_9999; clear = 1'b1;
    r_addr = {6'd9, 6'd7};
    cyc();
    clear = 1'b0; we = 1'b0;
    count_busy(1'b1);
    sweep_read();

    // Reset mid-sweep restarts from address 0.
    write(6'd2, 32'h0202_0202);
    write(6'd40, 32'h4141_4141);
    clear = 1'b1; r_addr = '0;
    cyc();
    clear = 1'b0;
    idle(20);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    count_busy(1'b0);
    sweep_read();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
